// File: rtl/gray_code_pkg.sv
// Shared Gray-code helpers and types for the Gray pointer path.
package gray_code_pkg;

  localparam int unsigned DEFAULT_DATA_WIDTH = 32;

  // Source of the next count value, in priority order load > step > hold.
  typedef enum logic [1:0] {
    NEXT_HOLD,
    NEXT_LOAD,
    NEXT_INC,
    NEXT_DEC
  } next_sel_e;

  function automatic logic [DEFAULT_DATA_WIDTH-1:0] bin_to_gray(
    input logic [DEFAULT_DATA_WIDTH-1:0] bin
  );
    return bin ^ (bin >> 1);
  endfunction

  // Each binary bit is the XOR of all Gray bits at or above it.
  function automatic logic [DEFAULT_DATA_WIDTH-1:0] gray_to_bin(
    input logic [DEFAULT_DATA_WIDTH-1:0] gray
  );
    logic [DEFAULT_DATA_WIDTH-1:0] bin;
    bin = '0;
    bin[DEFAULT_DATA_WIDTH-1] = gray[DEFAULT_DATA_WIDTH-1];
    for (int unsigned i = 1; i < DEFAULT_DATA_WIDTH; i++) begin
      bin[DEFAULT_DATA_WIDTH-1-i] = bin[DEFAULT_DATA_WIDTH-i] ^ gray[DEFAULT_DATA_WIDTH-1-i];
    end
    return bin;
  endfunction

  function automatic int popcount(input logic [DEFAULT_DATA_WIDTH-1:0] v);
    int n;
    n = 0;
    for (int unsigned i = 0; i < DEFAULT_DATA_WIDTH; i++) begin
      n += int'(v[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/binary_to_gray_encoder.sv
// Purely combinational binary-to-Gray encoder.
module binary_to_gray_encoder #(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] bin_in,
  output logic [DATA_WIDTH-1:0] gray_out
);

  // Gray = bin XOR (bin >> 1); the MSB passes straight through.
  always_comb begin
    gray_out = bin_in ^ (bin_in >> 1);
  end

endmodule

// File: rtl/binary_to_gray_pointer_counter.sv
// Up/down binary counter with a registered Gray copy for clock-domain crossing.
// Binary and Gray register from the same next value, so Gray never lags.
module binary_to_gray_pointer_counter
  import gray_code_pkg::*;
#(
  parameter int unsigned           DATA_WIDTH  = DEFAULT_DATA_WIDTH,
  parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic                  Clock_In,
  input  logic                  Reset_n_In,
  input  logic                  Enable_In,
  input  logic                  Direction_In,
  input  logic                  Load_In,
  input  logic [DATA_WIDTH-1:0] Load_Data_In,
  output logic [DATA_WIDTH-1:0] Binary_Count_Out,
  output logic [DATA_WIDTH-1:0] Gray_Count_Out,
  output logic                  Wrap_Out,
  output logic                  Multi_Bit_Change_Out,
  output logic                  Gray_Stable_Out
);

  localparam logic [DATA_WIDTH-1:0] ONE        = {{(DATA_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [DATA_WIDTH-1:0] RESET_GRAY = RESET_VALUE ^ (RESET_VALUE >> 1);

  next_sel_e             sel;
  logic [DATA_WIDTH-1:0] count_d, count_q;
  logic [DATA_WIDTH-1:0] gray_d, gray_q;
  logic [DATA_WIDTH-1:0] gray_diff;
  logic                  wrap_d, wrap_q;
  logic                  multi_d, multi_q;
  logic                  stable_d, stable_q;

  // Pick the next-value source: load beats step, step beats hold.
  always_comb begin
    sel = NEXT_HOLD;
    if (Load_In) begin
      sel = NEXT_LOAD;
    end else if (Enable_In) begin
      sel = Direction_In ? NEXT_INC : NEXT_DEC;
    end
  end

  // Next count and wrap detection; a load never reports a wrap.
  always_comb begin
    count_d = count_q;
    wrap_d  = 1'b0;
    case (sel)
      NEXT_LOAD: count_d = Load_Data_In;
      NEXT_INC: begin
        count_d = count_q + ONE;
        wrap_d  = &count_q;
      end
      NEXT_DEC: begin
        count_d = count_q - ONE;
        wrap_d  = ~|count_q;
      end
      default: count_d = count_q;
    endcase
  end

  binary_to_gray_encoder #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_encoder (
    .bin_in  (count_d),
    .gray_out(gray_d)
  );

  // More than one Gray bit set in the diff <=> clearing its lowest set bit leaves something.
  always_comb begin
    gray_diff = gray_d ^ gray_q;
    multi_d   = (sel == NEXT_LOAD) && ((gray_diff & (gray_diff - ONE)) != '0);
    stable_d  = ~multi_d;
  end

  // Count, Gray and flag registers; reset discards everything immediately.
  always_ff @(posedge Clock_In or negedge Reset_n_In) begin
    if (!Reset_n_In) begin
      count_q  <= RESET_VALUE;
      gray_q   <= RESET_GRAY;
      wrap_q   <= 1'b0;
      multi_q  <= 1'b0;
      stable_q <= 1'b0;
    end else begin
      count_q  <= count_d;
      gray_q   <= gray_d;
      wrap_q   <= wrap_d;
      multi_q  <= multi_d;
      stable_q <= stable_d;
    end
  end

  assign Binary_Count_Out     = count_q;
  assign Gray_Count_Out       = gray_q;
  assign Wrap_Out             = wrap_q;
  assign Multi_Bit_Change_Out = multi_q;
  assign Gray_Stable_Out      = stable_q;

endmodule

// File: tb/tb_binary_to_gray_pointer_counter.sv
// Bench for binary_to_gray_pointer_counter: scoreboard of expected outputs per cycle
// plus directed checks against fixed constants.
module tb_binary_to_gray_pointer_counter;
  import gray_code_pkg::*;

  localparam int unsigned W = 32;

  typedef struct {
    logic [W-1:0] bin;
    logic [W-1:0] gray;
    logic         wrap;
    logic         multi;
    logic         stable;
    logic         is_step;
  } exp_t;

  logic         clk;
  logic         rst_n;
  logic         en;
  logic         dir;
  logic         load;
  logic [W-1:0] load_data;
  logic [W-1:0] bin_out;
  logic [W-1:0] gray_out;
  logic         wrap_out;
  logic         multi_out;
  logic         stable_out;

  exp_t         sb[$];
  logic [W-1:0] m_bin;
  int           n_vec;
  int           n_err;

  binary_to_gray_pointer_counter #(
    .DATA_WIDTH (W),
    .RESET_VALUE(32'h0000_0000)
  ) dut (
    .Clock_In            (clk),
    .Reset_n_In          (rst_n),
    .Enable_In           (en),
    .Direction_In        (dir),
    .Load_In             (load),
    .Load_Data_In        (load_data),
    .Binary_Count_Out    (bin_out),
    .Gray_Count_Out      (gray_out),
    .Wrap_Out            (wrap_out),
    .Multi_Bit_Change_Out(multi_out),
    .Gray_Stable_Out     (stable_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got running want finished");
    $fatal(1, "watchdog");
  end

  // Scoreboard consumer: one expected entry per clocked cycle while a test is stepping.
  logic [W-1:0] prev_gray;
  initial prev_gray = '0;
  always begin : monitor
    exp_t e;
    @(posedge clk);
    #1;
    if (sb.size() != 0) begin
      e = sb.pop_front();
      n_vec++;
      if (bin_out !== e.bin) begin
        n_err++;
        $display("FAIL sb_bin got %h want %h", bin_out, e.bin);
      end
      n_vec++;
      if (gray_out !== e.gray) begin
        n_err++;
        $display("FAIL sb_gray got %h want %h", gray_out, e.gray);
      end
      n_vec++;
      if (wrap_out !== e.wrap) begin
        n_err++;
        $display("FAIL sb_wrap got %b want %b", wrap_out, e.wrap);
      end
      n_vec++;
      if (multi_out !== e.multi) begin
        n_err++;
        $display("FAIL sb_multi got %b want %b", multi_out, e.multi);
      end
      n_vec++;
      if (stable_out !== e.stable) begin
        n_err++;
        $display("FAIL sb_stable got %b want %b", stable_out, e.stable);
      end
      n_vec++;
      if (gray_to_bin(gray_out) !== bin_out) begin
        n_err++;
        $display("FAIL sb_decode got %h want %h", gray_to_bin(gray_out), bin_out);
      end
      if (e.is_step) begin
        n_vec++;
        if (popcount(gray_out ^ prev_gray) != 1) begin
          n_err++;
          $display("FAIL sb_one_bit got %0d want 1", popcount(gray_out ^ prev_gray));
        end
      end
    end
    prev_gray = gray_out;
  end

  // Drive one cycle of stimulus, push the model's prediction, return after the edge.
  task automatic step(input logic ld, input logic [W-1:0] d, input logic e_in, input logic dr);
    exp_t         e;
    logic [W-1:0] nxt;
    @(negedge clk);
    load      = ld;
    load_data = d;
    en        = e_in;
    dir       = dr;
    if (ld)        nxt = d;
    else if (e_in) nxt = dr ? m_bin + 32'd1 : m_bin - 32'd1;
    else           nxt = m_bin;
    e.bin     = nxt;
    e.gray    = nxt ^ (nxt >> 1);
    e.wrap    = !ld && e_in && ((dr && m_bin == 32'hFFFF_FFFF) || (!dr && m_bin == 32'h0));
    e.multi   = ld && (popcount(e.gray ^ (m_bin ^ (m_bin >> 1))) > 1);
    e.stable  = !e.multi;
    e.is_step = !ld && e_in;
    sb.push_back(e);
    m_bin = nxt;
    @(posedge clk);
    #2;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b1; dir = 1'b1; load = 1'b0; load_data = '0;
    #3;
    n_vec++;
    if ({bin_out, gray_out, wrap_out, multi_out, stable_out} !== {67{1'b0}}) begin
      n_err++;
      $display("FAIL reset_init got %h/%h/%b%b%b want 0/0/000", bin_out, gray_out, wrap_out, multi_out, stable_out);
    end
    repeat (2) @(posedge clk);
    #2;
    n_vec++;
    if (bin_out !== 32'h0) begin
      n_err++;
      $display("FAIL reset_hold got %h want 00000000", bin_out);
    end
    @(negedge clk);
    en = 1'b0; dir = 1'b0;
    rst_n = 1'b1;
    #1;
    n_vec++;
    if (stable_out !== 1'b0) begin
      n_err++;
      $display("FAIL reset_stable_pre got %b want 0", stable_out);
    end
    @(posedge clk);
    #2;
    n_vec++;
    if (stable_out !== 1'b1) begin
      n_err++;
      $display("FAIL reset_stable_post got %b want 1", stable_out);
    end
    m_bin = '0;
  endtask

  task automatic test_async_reset();
    step(1'b1, 32'h0000_1234, 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0);
    n_vec++;
    if (bin_out !== 32'h0000_1234) begin
      n_err++;
      $display("FAIL async_pre got %h want 00001234", bin_out);
    end
    @(negedge clk);
    en = 1'b1; dir = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    n_vec++;
    if ({bin_out, gray_out, wrap_out, multi_out, stable_out} !== {67{1'b0}}) begin
      n_err++;
      $display("FAIL async_reset got %h/%h/%b%b%b want 0/0/000", bin_out, gray_out, wrap_out, multi_out, stable_out);
    end
    @(posedge clk);
    #2;
    n_vec++;
    if (bin_out !== 32'h0) begin
      n_err++;
      $display("FAIL async_hold got %h want 00000000", bin_out);
    end
    @(negedge clk);
    en = 1'b0; dir = 1'b0;
    rst_n = 1'b1;
    #1;
    n_vec++;
    if (stable_out !== 1'b0) begin
      n_err++;
      $display("FAIL async_stable_pre got %b want 0", stable_out);
    end
    @(posedge clk);
    #2;
    n_vec++;
    if (stable_out !== 1'b1 || bin_out !== 32'h0) begin
      n_err++;
      $display("FAIL async_release got %b/%h want 1/00000000", stable_out, bin_out);
    end
    m_bin = '0;
  endtask

  task automatic test_increment();
    for (int i = 0; i < 5; i++) step(1'b0, '0, 1'b1, 1'b1);
    n_vec++;
    if (bin_out !== 32'h0000_0005 || gray_out !== 32'h0000_0007) begin
      n_err++;
      $display("FAIL inc5 got %h/%h want 00000005/00000007", bin_out, gray_out);
    end
  endtask

  task automatic test_up_wrap();
    step(1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0);
    n_vec++;
    if (wrap_out !== 1'b0) begin
      n_err++;
      $display("FAIL upwrap_load got %b want 0", wrap_out);
    end
    step(1'b0, '0, 1'b1, 1'b1);
    n_vec++;
    if (bin_out !== 32'h0 || gray_out !== 32'h0 || wrap_out !== 1'b1) begin
      n_err++;
      $display("FAIL upwrap got %h/%h/%b want 00000000/00000000/1", bin_out, gray_out, wrap_out);
    end
    step(1'b0, '0, 1'b0, 1'b0);
    n_vec++;
    if (wrap_out !== 1'b0) begin
      n_err++;
      $display("FAIL upwrap_pulse got %b want 0", wrap_out);
    end
  endtask

  task automatic test_down_wrap();
    step(1'b0, '0, 1'b1, 1'b0);
    n_vec++;
    if (bin_out !== 32'hFFFF_FFFF || gray_out !== 32'h8000_0000 || wrap_out !== 1'b1) begin
      n_err++;
      $display("FAIL downwrap got %h/%h/%b want ffffffff/80000000/1", bin_out, gray_out, wrap_out);
    end
    step(1'b0, '0, 1'b0, 1'b0);
    n_vec++;
    if (wrap_out !== 1'b0) begin
      n_err++;
      $display("FAIL downwrap_pulse got %b want 0", wrap_out);
    end
  endtask

  task automatic test_loads();
    step(1'b1, 32'h0, 1'b0, 1'b0);
    step(1'b1, 32'h5, 1'b0, 1'b0);
    n_vec++;
    if (multi_out !== 1'b1 || stable_out !== 1'b0) begin
      n_err++;
      $display("FAIL load5 got %b/%b want 1/0", multi_out, stable_out);
    end
    step(1'b0, '0, 1'b0, 1'b0);
    n_vec++;
    if (multi_out !== 1'b0 || stable_out !== 1'b1) begin
      n_err++;
      $display("FAIL load5_after got %b/%b want 0/1", multi_out, stable_out);
    end
    step(1'b1, 32'h0, 1'b0, 1'b0);
    step(1'b1, 32'h1, 1'b0, 1'b0);
    n_vec++;
    if (multi_out !== 1'b0 || stable_out !== 1'b1) begin
      n_err++;
      $display("FAIL load1 got %b/%b want 0/1", multi_out, stable_out);
    end
    step(1'b1, 32'h1, 1'b0, 1'b0);
    n_vec++;
    if (multi_out !== 1'b0 || stable_out !== 1'b1) begin
      n_err++;
      $display("FAIL load_same got %b/%b want 0/1", multi_out, stable_out);
    end
    step(1'b1, 32'h10, 1'b1, 1'b1);
    n_vec++;
    if (bin_out !== 32'h10 || wrap_out !== 1'b0) begin
      n_err++;
      $display("FAIL load_en got %h/%b want 00000010/0", bin_out, wrap_out);
    end
  endtask

  task automatic test_back_to_back();
    step(1'b1, 32'h0, 1'b0, 1'b0);
    step(1'b1, 32'h5, 1'b0, 1'b0);
    step(1'b1, 32'hA0, 1'b0, 1'b0);
    n_vec++;
    if (multi_out !== 1'b1 || stable_out !== 1'b0) begin
      n_err++;
      $display("FAIL b2b got %b/%b want 1/0", multi_out, stable_out);
    end
    step(1'b0, '0, 1'b1, 1'b1);
    n_vec++;
    if (stable_out !== 1'b1 || bin_out !== 32'hA1) begin
      n_err++;
      $display("FAIL b2b_after got %b/%h want 1/000000a1", stable_out, bin_out);
    end
  endtask

  task automatic test_random();
    logic         ld;
    logic [W-1:0] d;
    for (int i = 0; i < 10000; i++) begin
      ld = ($urandom_range(0, 15) == 0);
      case ($urandom_range(0, 3))
        0:       d = 32'h0;
        1:       d = 32'hFFFF_FFFF;
        default: d = $urandom;
      endcase
      step(ld, d, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    m_bin = '0;
    test_reset();
    test_async_reset();
    test_increment();
    test_up_wrap();
    test_down_wrap();
    test_loads();
    test_back_to_back();
    test_random();
    step(1'b0, '0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #3;
    n_vec++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL sb_drain got %0d entries want 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
